// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 parallel-interface emulator.
package ad7606_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RST_HOLD = 2'd1,
    CONV     = 2'd2,
    READY    = 2'd3
  } state_e;

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned NUM_WORDS   = 16;
  localparam int unsigned SAMPLE_W    = 18;
  localparam int unsigned CH_W        = 3;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned WORD_W      = 16;
  localparam int unsigned FRAME_CNT_W = 15;
  localparam int unsigned OS_W        = 3;

  // os code 7 is reserved on the real part and behaves like no oversampling
  localparam logic [OS_W-1:0] OS_NONE_CODE = 3'd7;

  typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] frame_t;

  function automatic logic [OS_W-1:0] os_eff(input logic [OS_W-1:0] os);
    return (os == OS_NONE_CODE) ? OS_W'(0) : os;
  endfunction

endpackage

// File: rtl/ad7606_emu_wordmux.sv
// Combinational mapping of (frame, read index) to the 16-bit parallel word.
module ad7606_emu_wordmux
  import ad7606_pkg::*;
(
  input  frame_t            frame,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word_c
);

  logic [CH_W-1:0]     ch;
  logic [SAMPLE_W-1:0] smp;

  // Even words carry sample MSBs, odd words the 2 LSBs plus channel tag
  always_comb begin
    word_c = '0;
    ch     = idx[3:1];
    smp    = frame[ch];
    if (idx < IDX_W'(NUM_WORDS)) begin
      if (idx[0]) word_c = {smp[1:0], 1'b0, ch, 10'b0};
      else        word_c = smp[17:2];
    end
  end

endmodule

// File: rtl/ad7606_emu.sv
// AD7606 emulator: convst-driven conversion timing, frame latch and readout.
module ad7606_emu
  import ad7606_pkg::*;
#(
  parameter int unsigned         BUSY_CYCLES = 40,
  parameter logic [SAMPLE_W-1:0] FIX_DEF     = 18'h00000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ad_convstab,
  input  logic                ad_cs,
  input  logic                ad_rd,
  input  logic                ad_reset,
  input  logic [OS_W-1:0]     ad_os,
  input  logic                pat_sel,
  input  logic [SAMPLE_W-1:0] fix_val,
  output logic [WORD_W-1:0]   ad_data,
  output logic                ad_busy,
  output logic                first_data,
  output logic                err_overrun
);

  // Longest conversion is BUSY_CYCLES << 6
  localparam int unsigned CNT_W = $clog2(BUSY_CYCLES * 64 + 1);

  state_e                 state_q, state_d;
  logic                   convst_q, convst_d;
  logic                   rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  frame_t                 frame_q, frame_d;
  logic [WORD_W-1:0]      hold_q, hold_d;
  logic [WORD_W-1:0]      data_q, data_d;
  logic                   pres0_q, pres0_d;
  logic                   first_q, first_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [SAMPLE_W-1:0]    fix_cap_q, fix_cap_d;

  logic                   convst_edge;
  logic                   rd_fall;
  logic [CNT_W-1:0]       conv_len;
  logic [WORD_W-1:0]      word_c;

  ad7606_emu_wordmux u_wordmux (
    .frame  (frame_q),
    .idx    (idx_q),
    .word_c (word_c)
  );

  // Next-state: edge detection, conversion sequencing, readout, device reset
  always_comb begin
    state_d     = state_q;
    convst_d    = ad_convstab;
    rd_d        = ad_rd;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    pres0_d     = pres0_q;
    busy_d      = busy_q;
    err_d       = err_q;
    fix_cap_d   = fix_cap_q;

    convst_edge = ad_convstab & ~convst_q;
    rd_fall     = rd_q & ~ad_rd & ~ad_cs;
    conv_len    = CNT_W'(BUSY_CYCLES) << os_eff(ad_os);

    if (rd_fall) begin
      hold_d  = word_c;
      pres0_d = (idx_q == '0);
      if (idx_q < IDX_W'(NUM_WORDS)) idx_d = idx_q + IDX_W'(1);
    end

    case (state_q)
      IDLE, READY: begin
        if (convst_edge) begin
          state_d = CONV;
          busy_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = conv_len - CNT_W'(1);
        end
      end
      CONV: begin
        if (convst_edge) err_d = 1'b1;
        if (cnt_q == '0) begin
          fix_cap_d = fix_val;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            frame_d[k] = pat_sel ? fix_val : {CH_W'(k), frame_cnt_q};
          end
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          busy_d      = 1'b0;
          state_d     = READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RST_HOLD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (ad_reset) begin
      state_d     = RST_HOLD;
      convst_d    = 1'b0;
      rd_d        = 1'b0;
      cnt_d       = '0;
      frame_cnt_d = '0;
      idx_d       = '0;
      frame_d     = '0;
      hold_d      = '0;
      pres0_d     = 1'b0;
      busy_d      = 1'b0;
      err_d       = 1'b0;
      fix_cap_d   = FIX_DEF;
    end

    data_d  = ad_cs ? '0 : hold_d;
    first_d = ~ad_cs & pres0_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      convst_q    <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      data_q      <= '0;
      pres0_q     <= 1'b0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      fix_cap_q   <= FIX_DEF;
    end else begin
      state_q     <= state_d;
      convst_q    <= convst_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      data_q      <= data_d;
      pres0_q     <= pres0_d;
      first_q     <= first_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      fix_cap_q   <= fix_cap_d;
    end
  end

  assign ad_data     = data_q;
  assign ad_busy     = busy_q;
  assign first_data  = first_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_ad7606_emu.sv
// Self-checking bench for ad7606_emu: timing, readout tables, overrun, reset, wrap.
module tb_ad7606_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance (default timing)
  logic        convst = 1'b0, cs = 1'b1, rd = 1'b1, dreset = 1'b0, pat = 1'b0;
  logic [2:0]  os = 3'd0;
  logic [17:0] fix = 18'h0;
  logic [15:0] data;
  logic        busy, first, err;

  // Short-conversion instance for the frame counter wrap
  logic        convst_b = 1'b0, rd_b = 1'b1;
  logic [15:0] data_b;
  logic        busy_b, first_b, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ad7606_emu #(.BUSY_CYCLES(40)) dut (
    .clk(clk), .rst(rst), .ad_convstab(convst), .ad_cs(cs), .ad_rd(rd),
    .ad_reset(dreset), .ad_os(os), .pat_sel(pat), .fix_val(fix),
    .ad_data(data), .ad_busy(busy), .first_data(first), .err_overrun(err)
  );

  ad7606_emu #(.BUSY_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .ad_convstab(convst_b), .ad_cs(1'b0), .ad_rd(rd_b),
    .ad_reset(1'b0), .ad_os(3'd0), .pat_sel(1'b0), .fix_val(18'h0),
    .ad_data(data_b), .ad_busy(busy_b), .first_data(first_b), .err_overrun(err_b)
  );

  typedef struct {
    logic        pat;
    logic [17:0] fix;
    logic [15:0] data;
    logic        first;
  } rd_vec_t;

  rd_vec_t vec [34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rising convst edge, then busy must be up right after that edge
  task automatic conv_begin(input logic [2:0] os_v);
    tick();
    os     = os_v;
    convst = 1'b1;
    tick();
    chk("busy_rise", 32'(busy), 32'd1);
    convst = 1'b0;
  endtask

  // Count remaining busy cycles (the first one was seen in conv_begin)
  task automatic conv_wait(input string name, input int exp_w, input logic do_chk);
    int w = 1;
    int guard = 0;
    while (busy && guard < 5000) begin
      tick();
      guard++;
      if (busy) w++;
    end
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
    else if (do_chk) chk(name, 32'(w), 32'(exp_w));
  endtask

  task automatic rd_pulse(input string name, input logic [15:0] exp_d, input logic exp_f);
    tick();
    rd = 1'b0;
    tick();
    chk({name, "_data"}, 32'(data), 32'(exp_d));
    chk({name, "_first"}, 32'(first), 32'(exp_f));
    rd = 1'b1;
  endtask

  task automatic rd_pulse_b(input string name, input logic [15:0] exp_d, input logic exp_f);
    tick();
    rd_b = 1'b0;
    tick();
    chk({name, "_data"}, 32'(data_b), 32'(exp_d));
    chk({name, "_first"}, 32'(first_b), 32'(exp_f));
    rd_b = 1'b1;
  endtask

  initial begin
    logic [15:0] ramp_w [17];
    logic [15:0] fix_w  [17];
    int w;

    ramp_w = '{16'h0000, 16'h0000, 16'h2000, 16'h0400, 16'h4000, 16'h0800,
               16'h6000, 16'h0C00, 16'h8000, 16'h1000, 16'hA000, 16'h1400,
               16'hC000, 16'h1800, 16'hE000, 16'h1C00, 16'h0000};
    fix_w  = '{16'hFFFF, 16'hC000, 16'hFFFF, 16'hC400, 16'hFFFF, 16'hC800,
               16'hFFFF, 16'hCC00, 16'hFFFF, 16'hD000, 16'hFFFF, 16'hD400,
               16'hFFFF, 16'hD800, 16'hFFFF, 16'hDC00, 16'h0000};
    for (int i = 0; i < 17; i++) begin
      vec[i]      = '{pat: 1'b0, fix: 18'h00000, data: ramp_w[i], first: (i == 0)};
      vec[17 + i] = '{pat: 1'b1, fix: 18'h3FFFF, data: fix_w[i],  first: (i == 0)};
    end

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_first", 32'(first), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    cs  = 1'b0;
    repeat (2) tick();

    // Frame is all-zero before the first conversion
    rd_pulse("pre_conv_w0", 16'h0000, 1'b1);

    // Ramp frame 0 then fixed 3FFFF frame: 17 reads each
    for (int i = 0; i < 34; i++) begin
      if (i % 17 == 0) begin
        pat = vec[i].pat;
        fix = vec[i].fix;
        conv_begin(3'd0);
        conv_wait("busy_w_os0", 40, 1'b1);
      end
      rd_pulse($sformatf("vec%0d", i), vec[i].data, vec[i].first);
    end

    // Read during CONV returns the previous (fixed) frame; idx carries over
    pat = 1'b0;
    conv_begin(3'd0);
    rd_pulse("conv_rd_w0", 16'hFFFF, 1'b1);
    conv_wait("conv_rd_busy", 40, 1'b0);
    chk("conv_rd_busy_low", 32'(busy), 32'd0);
    rd_pulse("ramp2_w1", 16'h8000, 1'b0);

    // Chip select high blanks outputs and keeps idx
    cs = 1'b1;
    repeat (2) tick();
    chk("cs_hi_data", 32'(data), 32'd0);
    chk("cs_hi_first", 32'(first), 32'd0);
    cs = 1'b0;
    repeat (2) tick();
    chk("cs_lo_hold", 32'(data), 32'h8000);
    rd_pulse("ramp2_w2", 16'h2000, 1'b0);

    // Oversampling: os=3 stretches busy 8x, os=7 acts as os=0
    conv_begin(3'd3);
    conv_wait("busy_w_os3", 320, 1'b1);
    conv_begin(3'd7);
    conv_wait("busy_w_os7", 40, 1'b1);

    // Second convst 10 cycles into CONV: width unchanged, sticky overrun
    conv_begin(3'd0);
    w = 1;
    for (int g = 0; g < 200 && busy; g++) begin
      tick();
      if (busy) w++;
      convst = (w == 10);
    end
    convst = 1'b0;
    chk("ovr_busy_w", 32'(w), 32'd40);
    chk("ovr_err", 32'(err), 32'd1);
    repeat (5) tick();
    chk("ovr_err_sticky", 32'(err), 32'd1);
    dreset = 1'b1;
    tick();
    chk("dreset_err", 32'(err), 32'd0);
    chk("dreset_data", 32'(data), 32'd0);
    dreset = 1'b0;
    repeat (2) tick();

    // Rebuild a nonzero frame count, then ad_reset aborts a conversion
    repeat (3) begin
      conv_begin(3'd0);
      conv_wait("pre_abort_w", 40, 1'b1);
    end
    conv_begin(3'd0);
    repeat (5) tick();
    dreset = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    convst = 1'b1;
    tick();
    chk("hold_ignore_convst", 32'(busy), 32'd0);
    convst = 1'b0;
    dreset = 1'b0;
    repeat (2) tick();
    chk("hold_exit_busy", 32'(busy), 32'd0);
    conv_begin(3'd0);
    conv_wait("post_abort_w", 40, 1'b1);
    rd_pulse("post_abort_w0", 16'h0000, 1'b1);
    rd_pulse("post_abort_w1", 16'h0000, 1'b0);
    rd_pulse("post_abort_w2", 16'h2000, 1'b0);

    // Frame counter wrap on the short-conversion instance
    for (int n = 0; n < 32768; n++) begin
      tick();
      convst_b = 1'b1;
      tick();
      convst_b = 1'b0;
    end
    tick();
    chk("wrap_busy", 32'(busy_b), 32'd0);
    rd_pulse_b("cnt7fff_w0", 16'h1FFF, 1'b1);
    rd_pulse_b("cnt7fff_w1", 16'hC000, 1'b0);
    tick();
    convst_b = 1'b1;
    tick();
    convst_b = 1'b0;
    tick();
    rd_pulse_b("wrap_w0", 16'h0000, 1'b1);
    rd_pulse_b("wrap_w1", 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad7606_emu.md
AD7606_EMU -- requirements
Module: ad7606_emu

Interface
REQ-001 Parameter BUSY_CYCLES, default 40: base conversion time in clk cycles at oversampling ratio 0.
REQ-002 Parameter FIX_DEF, default 18'h00000: fixed-pattern value after reset.
REQ-003 clk  input  1  system clock; the single clock for the block.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ad_convstab  input  1  conversion start; rising edge starts a conversion.
REQ-006 ad_cs  input  1  chip select, active-low.
REQ-007 ad_rd  input  1  read strobe; falling edge while ad_cs=0 advances readout.
REQ-008 ad_reset  input  1  device reset, active-high.
REQ-009 ad_os  input  3  oversampling ratio exponent.
REQ-010 pat_sel  input  1  sample source: 0 = ramp, 1 = fixed.
REQ-011 fix_val  input  18  fixed sample value, captured at each conversion end.
REQ-012 ad_data  output  16  parallel data word.
REQ-013 ad_busy  output  1  conversion in progress, active-high.
REQ-014 first_data  output  1  high while word 0 (CH1 MSBs) is presented.
REQ-015 err_overrun  output  1  sticky flag: convst edge seen while busy.

Function
REQ-016 The state machine SHALL have states IDLE, RST_HOLD, CONV and READY.
REQ-017 An ad_convstab rising edge is defined as a sampled value of 1 following a prior-cycle value of 0 (one register stage).
REQ-018 A rising edge seen at cycle N in IDLE or READY SHALL raise ad_busy at N+1, clear the read index to 0 and enter CONV.
REQ-019 CONV SHALL last exactly BUSY_CYCLES << os_eff cycles, where os_eff = ad_os latched at the convst edge, and os_eff = 0 when ad_os = 7.
REQ-020 On the last CONV cycle the block SHALL latch the 8-sample frame, increment the 15-bit frame counter (wrapping at 32767 -> 0), drop ad_busy and enter READY.
REQ-021 In ramp mode, sample k (k = 0..7) SHALL be {k[2:0], frame_cnt[14:0]}, using the counter value before the increment; in fixed mode all 8 samples SHALL be fix_val.
REQ-022 Readout SHALL present 16 words: word 2k = sample_k[17:2]; word 2k+1 = {sample_k[1:0], 1'b0, k[2:0], 10'b0}.
REQ-023 An ad_rd falling edge with ad_cs=0 at cycle N SHALL drive word[idx] on ad_data from N+1 and then increment idx.
REQ-024 ad_data SHALL hold its value until the next qualifying edge.
REQ-025 When idx > 15, ad_data SHALL be 16'h0000 and idx SHALL saturate at 16.
REQ-026 first_data SHALL be 1 exactly while the presented word is word 0 and ad_cs=0.
REQ-027 While ad_cs=1, ad_data SHALL be 16'h0000 and first_data SHALL be 0; idx SHALL be retained.
REQ-028 Reads during CONV SHALL return words of the previously latched frame; the frame is all-zero before the first conversion.
REQ-029 A convst edge during CONV SHALL be ignored for timing and SHALL set err_overrun; err_overrun SHALL clear only on rst or ad_reset.
REQ-030 A convst edge in READY with readout incomplete SHALL start a new conversion normally; unread words are discarded.

Reset
REQ-031 rst=1 SHALL force state IDLE, ad_busy=0, ad_data=0, first_data=0, err_overrun=0, frame_cnt=0, idx=0, frame=0, convst/rd edge registers=0.
REQ-032 ad_reset=1 SHALL have the same effect as rst, with state RST_HOLD, including mid-CONV abort (ad_busy falls next cycle).
REQ-033 RST_HOLD SHALL be left to IDLE the cycle after ad_reset returns to 0.
REQ-034 Convst edges SHALL be ignored while in RST_HOLD.

Structure
REQ-035 A shared package ad7606_pkg SHALL hold the state encoding, channel count (8), words per frame (16), sample width (18) and the os=7 -> 0 mapping constant.
REQ-036 One sub-module, ad7606_emu_wordmux, SHALL map (frame, idx) to the 16-bit word combinationally; all sequencing SHALL stay in ad7606_emu.

Verification
REQ-037 Scenario 1: BUSY_CYCLES=40, os=0, convst pulse -> busy high 1 cycle after the edge for exactly 40 cycles; frame 0 ramp words 0/1 = 16'h0000 / 16'h0000, word 2 = 16'h2000, word 3 = 16'h0400.
REQ-038 Scenario 2: os=3 -> busy high 320 cycles; os=7 -> 40 cycles.
REQ-039 Scenario 3: pat_sel=1, fix_val=18'h3FFFF, 17 rd pulses -> words 2k = 16'hFFFF, words 2k+1 = {2'b11, 1'b0, k, 10'b0}; 17th word = 16'h0000; first_data high only on word 0.
REQ-040 Scenario 4: second convst 10 cycles into CONV -> busy width unchanged, err_overrun=1 until ad_reset.
REQ-041 Scenario 5: ad_reset asserted mid-CONV -> busy low next cycle, frame_cnt=0, next conversion yields frame 0 values.
REQ-042 Scenario 6: 32768 conversions in ramp mode -> frame_cnt wraps, word 0 returns to 16'h0000.
